// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types and constants shared by the fetch queue, decode and later pipeline registers.
`default_nettype none

package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {instr, pc} buffer between fetch and decode with valid/ready on
// both sides and a synchronous flush for PC redirects.
`default_nettype none

module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     f_valid,
  input  logic [XLEN-1:0]          f_instr,
  input  logic [XLEN-1:0]          f_pc,
  output logic                     f_ready,
  output logic                     d_valid,
  output logic [XLEN-1:0]          d_instr,
  output logic [XLEN-1:0]          d_pc,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic empty, full, push, pop;

  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign f_ready = ~full;
  assign d_valid = ~empty;
  assign push    = f_valid & f_ready & ~flush;
  assign pop     = d_valid & d_ready & ~flush;
  assign count   = wptr_q - rptr_q;

  // Empty never exposes storage, so unwritten entries cannot leak X downstream.
  assign d_instr = empty ? XLEN'(NOP_INSTR) : instr_mem[rptr_q[AW-1:0]];
  assign d_pc    = empty ? '0 : pc_mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q[AW-1:0]] <= f_instr;
      pc_mem[wptr_q[AW-1:0]]    <= f_pc;
    end
  end

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32).
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            f_valid = 1'b0;
  logic [XLEN-1:0] f_instr = '0;
  logic [XLEN-1:0] f_pc = '0;
  logic            f_ready;
  logic            d_valid;
  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_pc;
  logic            d_ready = 1'b0;
  logic [2:0]      count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_ready(f_ready),
    .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_ready(d_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
    f_valid = 1'b1; f_instr = instr; f_pc = pc;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_d_valid got %0b want 0", d_valid); end
    n_cmp++; if (f_ready !== 1'b1) begin n_err++; $display("FAIL rst_f_ready got %0b want 1", f_ready); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (d_instr !== NOP) begin n_err++; $display("FAIL rst_d_instr got %h want %h", d_instr, NOP); end
    n_cmp++; if (d_pc !== 32'h0) begin n_err++; $display("FAIL rst_d_pc got %h want 0", d_pc); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_order();
    logic [31:0] ins [3];
    ins[0] = 32'h0050_0093; ins[1] = 32'h00a0_0113; ins[2] = 32'h0020_81b3;
    d_ready = 1'b0;
    f_valid = 1'b1; f_instr = ins[0]; f_pc = 32'h0;
    n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_passthru got %0b want 0", d_valid); end
    for (int i = 0; i < 3; i++) begin
      f_valid = 1'b1; f_instr = ins[i]; f_pc = 32'(4 * i);
      tick();
      n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL basic_fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      n_cmp++; if (d_valid !== 1'b1 || d_pc !== 32'h0) begin n_err++; $display("FAIL basic_head[%0d] got v=%0b pc=%h want v=1 pc=0", i, d_valid, d_pc); end
    end
    f_valid = 1'b0;
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (d_instr !== ins[i] || d_pc !== 32'(4 * i)) begin n_err++; $display("FAIL basic_order[%0d] got %h/%h want %h/%h", i, d_instr, d_pc, ins[i], 4 * i); end
      tick();
      n_cmp++; if (count !== 3'(2 - i)) begin n_err++; $display("FAIL basic_drain_count[%0d] got %0d want %0d", i, count, 2 - i); end
    end
    d_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push1(32'h100 + 32'(i), 32'(4 * i));
    n_cmp++; if (f_ready !== 1'b0 || count !== 3'd4) begin n_err++; $display("FAIL full_state got rdy=%0b cnt=%0d want rdy=0 cnt=4", f_ready, count); end
    push1(32'h1ff, 32'h10);
    n_cmp++; if (count !== 3'd4 || d_pc !== 32'h0) begin n_err++; $display("FAIL full_ignore got cnt=%0d head=%h want cnt=4 head=0", count, d_pc); end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    n_cmp++; if (f_ready !== 1'b1 || count !== 3'd3) begin n_err++; $display("FAIL full_pop_frees got rdy=%0b cnt=%0d want rdy=1 cnt=3", f_ready, count); end
    push1(32'h104, 32'h10);
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (d_pc !== 32'(4 + 4 * i)) begin n_err++; $display("FAIL full_drain[%0d] got %h want %h", i, d_pc, 4 + 4 * i); end
      tick();
    end
    d_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || d_valid !== 1'b0) begin n_err++; $display("FAIL full_empty_after got cnt=%0d v=%0b want 0/0", count, d_valid); end
  endtask

  task automatic test_back_to_back();
    push1(32'h200, 32'h200);
    push1(32'h204, 32'h204);
    d_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      f_valid = 1'b1; f_pc = 32'h208 + 32'(4 * k); f_instr = f_pc;
      n_cmp++; if (count !== 3'd2 || d_pc !== 32'h200 + 32'(4 * k) || d_instr !== d_pc) begin
        n_err++; $display("FAIL b2b[%0d] got cnt=%0d pc=%h instr=%h want cnt=2 pc=%h", k, count, d_pc, d_instr, 32'h200 + 32'(4 * k));
      end
      tick();
    end
    f_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (d_pc !== 32'h228 + 32'(4 * k)) begin n_err++; $display("FAIL b2b_tail[%0d] got %h want %h", k, d_pc, 32'h228 + 32'(4 * k)); end
      tick();
    end
    d_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_final_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    push1(32'h30, 32'h30);
    push1(32'h34, 32'h34);
    push1(32'h38, 32'h38);
    flush = 1'b1; f_valid = 1'b1; f_pc = 32'h40; f_instr = 32'h40; d_ready = 1'b1;
    tick();
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || d_valid !== 1'b0 || d_instr !== NOP) begin
      n_err++; $display("FAIL flush_empty got cnt=%0d v=%0b instr=%h want 0/0/%h", count, d_valid, d_instr, NOP);
    end
    push1(32'h80, 32'h80);
    n_cmp++; if (count !== 3'd1 || d_valid !== 1'b1 || d_pc !== 32'h80) begin
      n_err++; $display("FAIL flush_next_push got cnt=%0d v=%0b pc=%h want 1/1/80", count, d_valid, d_pc);
    end
    flush = 1'b1; f_valid = 1'b1; f_pc = 32'h84;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (count !== 3'd0 || d_valid !== 1'b0) begin n_err++; $display("FAIL flush_held[%0d] got cnt=%0d v=%0b want 0/0", k, count, d_valid); end
    end
    flush = 1'b0; f_valid = 1'b0;
  endtask

  task automatic test_empty_pop();
    d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (count !== 3'd0 || d_valid !== 1'b0 || d_instr !== NOP || d_pc !== 32'h0) begin
        n_err++; $display("FAIL empty_pop[%0d] got cnt=%0d v=%0b instr=%h pc=%h want 0/0/%h/0", k, count, d_valid, d_instr, d_pc, NOP);
      end
    end
    d_ready = 1'b0;
    push1(32'h90, 32'h90);
    push1(32'h94, 32'h94);
    n_cmp++; if (count !== 3'd2 || d_pc !== 32'h90) begin n_err++; $display("FAIL empty_pop_after got cnt=%0d pc=%h want 2/90", count, d_pc); end
    push1(32'h98, 32'h98);
  endtask

  task automatic test_midstream_reset();
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_rst_pre got cnt=%0d want 3", count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (d_valid !== 1'b0 || count !== 3'd0 || f_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_ctrl got v=%0b cnt=%0d rdy=%0b want 0/0/1", d_valid, count, f_ready);
    end
    n_cmp++; if (d_instr !== NOP || d_pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_data got %h/%h want %h/0", d_instr, d_pc, NOP); end
    #2 reset = 1'b1;
    tick();
    push1(32'hA0, 32'hA0);
    n_cmp++; if (count !== 3'd1 || d_pc !== 32'hA0) begin n_err++; $display("FAIL mid_rst_resume got cnt=%0d pc=%h want 1/A0", count, d_pc); end
  endtask

  initial begin
    #3;
    test_reset();
    test_basic_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_empty_pop();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_queue

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers {instr, pc} pairs produced by fetch with a valid/ready handshake on both sides.
- Lets fetch run ahead while decode stalls, and discards all buffered instructions when execute redirects the PC (taken branch/jump).
- Fetch-side inputs come straight from the fetch stage outputs; decode-side outputs feed the decode stage.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2; elaboration-time assertion otherwise.
- XLEN, 32, instruction and PC width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 clears the queue immediately
- flush  input  1  synchronous discard of all entries (driven by execute branch-taken)
- f_valid  input  1  fetch presents a valid instruction
- f_instr  input  XLEN  instruction word from fetch
- f_pc  input  XLEN  PC of f_instr
- f_ready  output  1  queue accepts a push this cycle
- d_valid  output  1  head entry valid for decode
- d_instr  output  XLEN  head instruction
- d_pc  output  XLEN  head PC
- d_ready  input  1  decode consumes head this cycle
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry circular buffer of {instr, pc}. Read/write pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - empty = (wptr == rptr)
  - full = (index bits equal, MSBs differ)
- Handshakes:
  - push = f_valid & f_ready & ~flush
  - pop = d_valid & d_ready & ~flush
- f_ready = ~full, combinational from state only. It does not depend on d_ready, so there is no pop-to-push bypass when full.
- d_valid = ~empty.
- d_instr / d_pc:
  - When non-empty: head entry contents, combinational from storage.
  - When empty: d_instr = 32'h00000013 (NOP, addi x0,x0,0) and d_pc = 0.
- Latency: an entry pushed in cycle N is visible at d_* in cycle N+1. There is no same-cycle pass-through when empty.
- Push and pop in the same cycle (not full, not empty): both pointers advance and count is unchanged.
- Full: f_ready = 0 and f_valid is ignored. A pop while full frees a slot from the next cycle.
- Empty: d_valid = 0 and d_ready is ignored. Pointers do not move on pop.
- Wrap-around: pointers increment modulo 2*DEPTH, so index wraps DEPTH-1 -> 0 and the MSB toggles.
- Flush (flush=1 at a clock edge):
  - Next cycle: rptr = wptr = 0, count = 0, d_valid = 0.
  - Any simultaneous push or pop is discarded.
  - Flush has priority over push and pop.
  - Flush held for several cycles keeps the queue empty.
- Reset (reset=0), asynchronous and effective mid-operation:
  - pointers = 0, count = 0
  - d_valid = 0, f_ready = 1
  - d_instr = NOP, d_pc = 0
  - Storage contents are not reset; they are unobservable while empty.
- count = wptr - rptr, with (XLEN-independent) width $clog2(DEPTH)+1. Range 0..DEPTH.
- No X propagation: d_* are never driven from unwritten storage.

Decomposition:
- Shared package pipeline_pkg:
  - NOP_INSTR = 32'h00000013
  - typedef fetch_pkt_t = struct packed {logic[31:0] instr; logic[31:0] pc;}
  - Reused by decode and later pipeline registers.
- Storage and pointer logic stay in fetch_queue. No sub-module is needed; a generic FIFO split adds nothing at this size.

Test Plan:
- Reset: assert reset=0 mid-stream with 3 entries held -> same cycle d_valid=0, count=0, f_ready=1, d_instr=0x00000013, d_pc=0.
- Basic order: push (0x00500093, pc 0x0), (0x00a00113, pc 0x4), (0x002081b3, pc 0x8) with d_ready=0, then d_ready=1 -> outputs appear in push order over 3 cycles. d_valid is first seen the cycle after the first push. count goes 1,2,3 then 2,1,0.
- Full/backpressure (DEPTH=4): push 4 entries with d_ready=0 -> f_ready=0 and count=4. A 5th f_valid with pc 0x10 is not stored. One pop -> f_ready=1 next cycle, and the next push with pc 0x10 is the last entry drained.
- Simultaneous push+pop: 2 entries held, push and pop together for 10 cycles -> count stays 2 and PCs drain in strict order. Pointers wrap at least twice with no loss or duplication.
- Flush: 3 entries held, flush=1 with f_valid=1 (pc 0x40) and d_ready=1 in the same cycle -> next cycle count=0 and d_valid=0. Neither pc 0x40 nor the popped head is delivered. The following push (pc 0x80) appears the cycle after.
- Empty pop: d_ready=1 with the queue empty for 3 cycles -> pointers unchanged, count=0, d_instr holds NOP.
